// File: rtl/usb_fifo_pkg.sv
// Shared types and defaults for the USB FIFO arbiter: FSM states, grant encoding, timing defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_fifo_pkg;

  localparam int STROBE_CYCLES_DEF = 2;  // rd/wr low-pulse width in clk cycles
  localparam int TURN_CYCLES_DEF   = 1;  // bus turnaround idle cycles after each transfer

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    RECOVER
  } state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

  // Saturating increment used by the optional transfer counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/usb_fifo_arbiter_if.sv
// Bundles the FIFO-chip bus and the host rx/tx handshakes of the arbiter.
// Latency: n/a (wires only).
// Backpressure: rx uses valid/ready toward the host; tx uses valid plus a one-cycle ready pulse.
// master: arbiter side (drives rd/wr/data_out/data_oe, rx_data/rx_valid, tx_ready).
// slave : environment side (FIFO chip + host logic).
interface usb_fifo_arbiter_if;
  logic       rxf;       // FIFO has an RX byte, active-low
  logic       txe;       // FIFO can take a TX byte, active-low
  logic [7:0] data_in;   // byte read from the FIFO bus
  logic       rd;        // read strobe, active-low
  logic       wr;        // write strobe, active-low
  logic [7:0] data_out;  // byte driven onto the FIFO bus
  logic       data_oe;   // drive enable for data_out
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rxf, txe, data_in, rx_ready, tx_data, tx_valid,
    output rd, wr, data_out, data_oe, rx_data, rx_valid, tx_ready
  );

  modport slave (
    output rxf, txe, data_in, rx_ready, tx_data, tx_valid,
    input  rd, wr, data_out, data_oe, rx_data, rx_valid, tx_ready
  );
endinterface

// File: rtl/usb_fifo_strobe_timer.sv
// 4-bit down-counter timing strobe and turnaround phases.
// Latency: done is high in the load_val-th cycle after the start cycle.
// Backpressure: none; start always reloads, done pulses once per load.
// Ports: clk, reset_in (async, active-high), start, load_val[3:0], done.
module usb_fifo_strobe_timer (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       start,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      cnt <= 4'd0;
    end else if (start) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // cnt==1 marks the last cycle of the timed phase; the counter parks at 0 afterwards.
  assign done = (cnt == 4'd1);

endmodule

// File: rtl/usb_fifo_arbiter.sv
// Arbitrates a half-duplex FIFO-chip bus between RX reads and TX writes, round-robin on contention.
// Latency: grant 1 cycle after request in IDLE; read = STROBE_CYCLES, write = 1 + STROBE_CYCLES, then TURN_CYCLES.
// Backpressure: no read while rx_valid is unconsumed; tx_ready pulses once per accepted byte.
// Ports: clk, reset_in (async, active-high), bus (usb_fifo_arbiter_if.master).
// Optional: define USB_FIFO_ARB_STATS_EN to add saturating rx_count/tx_count outputs.
module usb_fifo_arbiter
  import usb_fifo_pkg::*;
#(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEF,  // legal 1..15
  parameter int TURN_CYCLES   = TURN_CYCLES_DEF     // legal 1..15
) (
  input  logic                clk,
  input  logic                reset_in,
  usb_fifo_arbiter_if.master  bus
`ifdef USB_FIFO_ARB_STATS_EN
  ,
  output logic [15:0]         rx_count,
  output logic [15:0]         tx_count
`endif
);

  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES);

  state_t     state, state_nxt;
  grant_t     last_grant, last_grant_nxt;
  logic       tmr_start;
  logic [3:0] tmr_load;
  logic       tmr_done;
  logic       rx_req, tx_req;
  logic       rd_done, wr_done;

  // Requests only matter in IDLE; once a strobe starts rxf/txe are ignored.
  assign rx_req  = ~bus.rxf & ~bus.rx_valid;
  assign tx_req  = ~bus.txe & bus.tx_valid;
  assign rd_done = (state == RD_STROBE) && tmr_done;
  assign wr_done = (state == WR_STROBE) && tmr_done;

  usb_fifo_strobe_timer u_timer (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    tmr_start      = 1'b0;
    tmr_load       = STROBE_LD;
    unique case (state)
      IDLE: begin
        // RX wins when alone, or when contended and TX had the previous grant.
        if (rx_req && (!tx_req || last_grant == GRANT_TX)) begin
          state_nxt      = RD_STROBE;
          last_grant_nxt = GRANT_RX;
          tmr_start      = 1'b1;
        end else if (tx_req) begin
          state_nxt      = WR_SETUP;
          last_grant_nxt = GRANT_TX;
        end
      end
      RD_STROBE, WR_STROBE: begin
        if (tmr_done) begin
          state_nxt = RECOVER;
          tmr_start = 1'b1;
          tmr_load  = TURN_LD;
        end
      end
      WR_SETUP: begin
        state_nxt = WR_STROBE;
        tmr_start = 1'b1;
      end
      RECOVER: begin
        if (tmr_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus controls are registered from state_nxt so the strobes come straight off flops.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state        <= IDLE;
      last_grant   <= GRANT_TX;
      bus.rd       <= 1'b1;
      bus.wr       <= 1'b1;
      bus.data_oe  <= 1'b0;
      bus.data_out <= 8'h00;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      bus.tx_ready <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      bus.rd       <= (state_nxt != RD_STROBE);
      bus.wr       <= (state_nxt != WR_STROBE);
      bus.data_oe  <= (state_nxt == WR_SETUP) || (state_nxt == WR_STROBE);
      bus.tx_ready <= (state_nxt == WR_SETUP);
      // Capture on entry to WR_SETUP so data_out is already on the bus during the setup cycle;
      // the host still holds tx_data because tx_ready has not pulsed yet.
      if (state == IDLE && state_nxt == WR_SETUP) bus.data_out <= bus.tx_data;
      if (rd_done) begin
        bus.rx_data  <= bus.data_in;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

`ifdef USB_FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      rx_count <= 16'd0;
      tx_count <= 16'd0;
    end else begin
      if (rd_done) rx_count <= sat_inc16(rx_count);
      if (wr_done) tx_count <= sat_inc16(tx_count);
    end
  end
`else
  // Without the statistics option, wr_done has no consumer.
  logic unused_wr_done;
  assign unused_wr_done = wr_done;
`endif

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Self-checking bench for usb_fifo_arbiter: directed scenarios plus randomized traffic.
// Instance a uses STROBE_CYCLES=2/TURN_CYCLES=1, instance b uses 5/3.
// A transaction-level model tracks pending rx bytes, accepted tx bytes, pulse widths and gaps.
`timescale 1ns/1ps
module tb_usb_fifo_arbiter;

  logic clk;
  logic rst_a, rst_b;
  int   n_chk, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  usb_fifo_arbiter_if ifa ();
  usb_fifo_arbiter_if ifb ();

  usb_fifo_arbiter #(.STROBE_CYCLES(2), .TURN_CYCLES(1)) u_dut_a (
    .clk(clk), .reset_in(rst_a), .bus(ifa.master));
  usb_fifo_arbiter #(.STROBE_CYCLES(5), .TURN_CYCLES(3)) u_dut_b (
    .clk(clk), .reset_in(rst_b), .bus(ifb.master));

  // Per-instance model state.
  int         rd_len[2], wr_len[2], gap[2], min_gap[2], wd_rx[2], wd_tx[2];
  int         rd_pulses[2], wr_pulses[2], txr_pulses[2], gcnt[2];
  logic       prev_rd[2], prev_wr[2], prev_txr[2], prev_rxq[2], prev_txq[2];
  logic       acc[2], rx_pend[2];
  logic [7:0] last_din[2], exp_rx[2], exp_tx[2], last_wr_dat[2];
  logic [7:0] glog[2][64];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called once per cycle at the falling edge with one instance's signals.
  task automatic mon_step(input int id, input int s, input int t, input logic rst,
                          input logic rd, input logic wr, input logic oe, input logic txr,
                          input logic rxv, input logic rxrdy, input logic rxf, input logic txe,
                          input logic txv, input logic [7:0] din, input logic [7:0] dout,
                          input logic [7:0] rxd, input logic [7:0] txd);
    int   bound;
    logic rxq, txq;
    bound = 2 * (s + t + 3);
    rxq = !rxf && !rxv;
    txq = !txe && txv;
    if (rst) begin
      chk_eq("rst_rd", rd, 1'b1);
      chk_eq("rst_wr", wr, 1'b1);
      chk_eq("rst_oe", oe, 1'b0);
      chk_eq("rst_tx_ready", txr, 1'b0);
      chk_eq("rst_rx_valid", rxv, 1'b0);
      prev_rd[id] = 1'b1; prev_wr[id] = 1'b1; prev_txr[id] = 1'b0;
      prev_rxq[id] = 1'b0; prev_txq[id] = 1'b0; acc[id] = 1'b0; rx_pend[id] = 1'b0;
      rd_len[id] = 0; wr_len[id] = 0; gap[id] = 99; wd_rx[id] = 0; wd_tx[id] = 0;
    end else begin
      // Strobe starts: the request must have been present in the preceding cycle.
      if (!rd && prev_rd[id]) begin
        chk_eq("rd_grant_req", prev_rxq[id], 1'b1);
        chk_eq("rd_turnaround", gap[id] >= t + 1, 1'b1);
        if (gap[id] < min_gap[id]) min_gap[id] = gap[id];
        glog[id][gcnt[id] % 64] = 8'h52;
        gcnt[id]++;
        rd_pulses[id]++;
      end
      if (txr && !prev_txr[id]) begin
        chk_eq("tx_grant_req", prev_txq[id], 1'b1);
        chk_eq("wr_turnaround", gap[id] >= t + 1, 1'b1);
        if (gap[id] < min_gap[id]) min_gap[id] = gap[id];
        glog[id][gcnt[id] % 64] = 8'h57;
        gcnt[id]++;
        txr_pulses[id]++;
      end
      if (txr) begin
        chk_eq("tx_ready_pulse", prev_txr[id], 1'b0);
        chk_eq("tx_accept_valid", txv, 1'b1);
        exp_tx[id] = txd;
      end
      // Read strobe: width, and the byte on data_in in its last cycle becomes rx_data.
      if (!rd) begin
        rd_len[id]++;
        last_din[id] = din;
      end else if (!prev_rd[id]) begin
        chk_eq("rd_width", rd_len[id], s);
        rd_len[id] = 0;
        gap[id] = 0;
        rx_pend[id] = 1'b1;
        exp_rx[id] = last_din[id];
      end
      // Write strobe: preceded by the setup cycle, data held for the whole pulse.
      if (!wr) begin
        if (prev_wr[id]) begin
          chk_eq("wr_after_setup", prev_txr[id], 1'b1);
          wr_pulses[id]++;
        end
        chk_eq("wr_data", dout, exp_tx[id]);
        last_wr_dat[id] = dout;
        wr_len[id]++;
      end else if (!prev_wr[id]) begin
        chk_eq("wr_width", wr_len[id], s);
        wr_len[id] = 0;
        gap[id] = 0;
      end
      if (rd && wr && !txr && gap[id] < 99) gap[id]++;
      chk_eq("rd_wr_excl", !rd && !wr, 1'b0);
      chk_eq("oe_while_rd", oe && !rd, 1'b0);
      chk_eq("data_oe", oe, txr || !wr);
      chk_eq("rx_valid", rxv, rx_pend[id]);
      if (rx_pend[id]) chk_eq("rx_data", rxd, exp_rx[id]);
      if (rx_pend[id] && rxrdy) rx_pend[id] = 1'b0;
      // Liveness: a standing request must be served within a bounded wait.
      if (rxq && rd) wd_rx[id]++; else wd_rx[id] = 0;
      if (txq && wr && !txr) wd_tx[id]++; else wd_tx[id] = 0;
      chk_eq("rx_starve", wd_rx[id] > bound, 1'b0);
      chk_eq("tx_starve", wd_tx[id] > bound, 1'b0);
      acc[id] = txv && txr;
      prev_rd[id] = rd; prev_wr[id] = wr; prev_txr[id] = txr;
      prev_rxq[id] = rxq; prev_txq[id] = txq;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon_step(0, 2, 1, rst_a, ifa.rd, ifa.wr, ifa.data_oe, ifa.tx_ready, ifa.rx_valid,
             ifa.rx_ready, ifa.rxf, ifa.txe, ifa.tx_valid, ifa.data_in, ifa.data_out,
             ifa.rx_data, ifa.tx_data);
    mon_step(1, 5, 3, rst_b, ifb.rd, ifb.wr, ifb.data_oe, ifb.tx_ready, ifb.rx_valid,
             ifb.rx_ready, ifb.rxf, ifb.txe, ifb.tx_valid, ifb.data_in, ifb.data_out,
             ifb.rx_data, ifb.tx_data);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_env(input logic acc_i, input logic txv_i, input logic [7:0] txd_i,
                          output logic rxf_o, output logic txe_o, output logic rxrdy_o,
                          output logic txv_o, output logic [7:0] din_o, output logic [7:0] txd_o);
    rxf_o   = ($urandom_range(0, 3) == 0);
    txe_o   = ($urandom_range(0, 3) == 0);
    rxrdy_o = 1'($urandom_range(0, 1));
    din_o   = 8'($urandom);
    txv_o   = txv_i;
    txd_o   = txd_i;
    // tx_data may only change once the current byte has been accepted.
    if (!txv_i || acc_i) begin
      txv_o = ($urandom_range(0, 2) != 0);
      txd_o = 8'($urandom);
    end
  endtask

  int         p_rd, p_wr, p_tr, g0;
  logic [7:0] exp_g;
  logic       r_rxf, r_txe, r_rdy, r_txv;
  logic [7:0] r_din, r_txd;

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 2; i++) begin
      min_gap[i] = 99; gcnt[i] = 0; rd_pulses[i] = 0; wr_pulses[i] = 0; txr_pulses[i] = 0;
    end
    ifa.rxf = 1; ifa.txe = 1; ifa.data_in = 0; ifa.rx_ready = 0; ifa.tx_data = 0; ifa.tx_valid = 0;
    ifb.rxf = 1; ifb.txe = 1; ifb.data_in = 0; ifb.rx_ready = 0; ifb.tx_data = 0; ifb.tx_valid = 0;
    rst_a = 1; rst_b = 1;
    repeat (3) step();
    chk_eq("rst_data_out", ifa.data_out, 8'h00);
    chk_eq("rst_rx_data", ifa.rx_data, 8'h00);
    chk_eq("rst_rx_data_b", ifb.rx_data, 8'h00);
    rst_a = 0; rst_b = 0;
    step();

    // Single read with the host not ready: exactly one 2-cycle strobe, then hold.
    p_rd = rd_pulses[0];
    ifa.rxf = 0; ifa.data_in = 8'hA5; ifa.rx_ready = 0;
    step();
    chk_eq("read_latency", ifa.rd, 1'b0);
    step();
    chk_eq("read_cycle2", ifa.rd, 1'b0);
    step();
    chk_eq("read_end", ifa.rd, 1'b1);
    chk_eq("read_rx_data", ifa.rx_data, 8'hA5);
    chk_eq("read_rx_valid", ifa.rx_valid, 1'b1);
    repeat (30) step();
    chk_eq("read_no_second", rd_pulses[0] - p_rd, 1);
    ifa.rxf = 1; ifa.rx_ready = 1; ifa.data_in = 8'h00;
    repeat (3) step();
    chk_eq("read_consumed", ifa.rx_valid, 1'b0);
    chk_eq("read_data_kept", ifa.rx_data, 8'hA5);
    ifa.rx_ready = 0;

    // Single write.
    p_wr = wr_pulses[0]; p_tr = txr_pulses[0];
    ifa.txe = 0; ifa.tx_valid = 1; ifa.tx_data = 8'h3C;
    for (int i = 0; i < 12; i++) begin
      step();
      if (acc[0]) begin ifa.tx_valid = 0; ifa.tx_data = 8'h00; end
    end
    chk_eq("write_tx_ready_pulses", txr_pulses[0] - p_tr, 1);
    chk_eq("write_wr_pulses", wr_pulses[0] - p_wr, 1);
    chk_eq("write_data", last_wr_dat[0], 8'h3C);
    chk_eq("write_oe_off", ifa.data_oe, 1'b0);

    // FIFO full: pending tx must wait.
    p_wr = wr_pulses[0]; p_tr = txr_pulses[0];
    ifa.txe = 1; ifa.tx_valid = 1; ifa.tx_data = 8'h5A;
    repeat (50) step();
    chk_eq("full_no_wr", wr_pulses[0] - p_wr, 0);
    chk_eq("full_no_tx_ready", txr_pulses[0] - p_tr, 0);
    chk_eq("full_wr_high", ifa.wr, 1'b1);
    ifa.tx_valid = 0;

    // Contention straight after reset: RD, WR, RD, WR ...
    rst_a = 1; step(); rst_a = 0;
    g0 = gcnt[0];
    ifa.rxf = 0; ifa.txe = 0; ifa.tx_valid = 1; ifa.rx_ready = 1; ifa.tx_data = 8'h11;
    for (int i = 0; i < 40; i++) begin
      ifa.data_in = 8'($urandom);
      step();
      if (acc[0]) ifa.tx_data = 8'($urandom);
    end
    chk_eq("contention_grants", gcnt[0] - g0 >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 8'h52 : 8'h57;
      chk_eq("grant_order", glog[0][(g0 + i) % 64], exp_g);
    end
    ifa.rxf = 1; ifa.txe = 1; ifa.tx_valid = 0; ifa.rx_ready = 0;
    repeat (10) step();

    // Reset during the second read-strobe cycle aborts the read.
    rst_a = 1; step(); rst_a = 0;
    p_rd = rd_pulses[0];
    ifa.rxf = 0; ifa.data_in = 8'h77;
    step();
    step();
    rst_a = 1;
    #1;
    chk_eq("abort_rd", ifa.rd, 1'b1);
    chk_eq("abort_rx_valid", ifa.rx_valid, 1'b0);
    chk_eq("abort_wr", ifa.wr, 1'b1);
    ifa.rxf = 1;
    step();
    rst_a = 0;
    repeat (10) step();
    chk_eq("abort_no_rx", ifa.rx_valid, 1'b0);
    chk_eq("abort_rx_data", ifa.rx_data, 8'h00);
    chk_eq("abort_pulses", rd_pulses[0] - p_rd, 1);

    // Long strobe / long turnaround instance.
    p_rd = rd_pulses[1];
    ifb.rxf = 0; ifb.rx_ready = 1; ifb.data_in = 8'hC3;
    repeat (60) step();
    chk_eq("b_reads", rd_pulses[1] - p_rd >= 3, 1'b1);
    chk_eq("b_min_gap", min_gap[1], 4);
    ifb.rxf = 1;
    repeat (10) step();

    // Randomized traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      rand_env(acc[0], ifa.tx_valid, ifa.tx_data, r_rxf, r_txe, r_rdy, r_txv, r_din, r_txd);
      ifa.rxf = r_rxf; ifa.txe = r_txe; ifa.rx_ready = r_rdy;
      ifa.tx_valid = r_txv; ifa.data_in = r_din; ifa.tx_data = r_txd;
      rand_env(acc[1], ifb.tx_valid, ifb.tx_data, r_rxf, r_txe, r_rdy, r_txv, r_din, r_txd);
      ifb.rxf = r_rxf; ifb.txe = r_txe; ifb.rx_ready = r_rdy;
      ifb.tx_valid = r_txv; ifb.data_in = r_din; ifb.tx_data = r_txd;
      step();
    end
    chk_eq("rand_a_reads", rd_pulses[0] > 100, 1'b1);
    chk_eq("rand_a_writes", wr_pulses[0] > 100, 1'b1);
    chk_eq("rand_b_writes", wr_pulses[1] > 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
